// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-pipe result FIFOs merged onto a single register-file
// write port, granted by fixed priority or round-robin, with a registered output.
module wb_arbiter #(
  parameter int NUM_PIPES = 4,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int DEPTH     = 2,
  parameter int ARB_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PIPES-1:0]          in_valid,
  output logic [NUM_PIPES-1:0]          in_ready,
  input  logic [NUM_PIPES-1:0]          in_reg_write,
  input  logic [NUM_PIPES*REG_W-1:0]    in_rd,
  input  logic [NUM_PIPES*DATA_W-1:0]   in_data,
  output logic                          wr_en,
  output logic [REG_W-1:0]              wr_rd,
  output logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(NUM_PIPES)-1:0]  wr_pipe,
  output logic                          pending
);

  localparam int PW = $clog2(NUM_PIPES);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 1 + REG_W + DATA_W;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [PW-1:0] PIPE_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] LAST_PIPE = PW'(NUM_PIPES - 1);
  localparam bit            RR_MODE   = (ARB_MODE == 32'sd1);

  // Entry layout: {reg_write, rd, data}
  logic [EW-1:0]       mem_q    [NUM_PIPES][DEPTH];
  logic [EW-1:0]       mem_d    [NUM_PIPES][DEPTH];
  logic [AW-1:0]       wr_ptr_q [NUM_PIPES];
  logic [AW-1:0]       wr_ptr_d [NUM_PIPES];
  logic [AW-1:0]       rd_ptr_q [NUM_PIPES];
  logic [AW-1:0]       rd_ptr_d [NUM_PIPES];
  logic [CW-1:0]       count_q  [NUM_PIPES];
  logic [CW-1:0]       count_d  [NUM_PIPES];
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [REG_W-1:0]    wr_rd_q, wr_rd_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [PW-1:0]       wr_pipe_q, wr_pipe_d;
  logic                out_vld_q, out_vld_d;

  logic [NUM_PIPES-1:0] nonempty_s;
  logic [NUM_PIPES-1:0] push_s;
  logic [NUM_PIPES-1:0] pop_s;
  logic [NUM_PIPES-1:0] take_hi_s;
  logic [NUM_PIPES-1:0] take_wrap_s;
  logic                 grant_vld_s;
  logic [PW-1:0]        grant_idx_s;
  logic [EW-1:0]        head_s;
  logic                 head_rw_s;
  logic [REG_W-1:0]     head_rd_s;
  logic [DATA_W-1:0]    head_data_s;

  // Buffer occupancy flags and ready, derived from counts only
  always_comb begin
    nonempty_s = {NUM_PIPES{1'b0}};
    in_ready   = {NUM_PIPES{1'b0}};
    for (int i = 0; i < NUM_PIPES; i++) begin
      nonempty_s[i] = (count_q[i] != {CW{1'b0}});
      in_ready[i]   = (count_q[i] < CNT_FULL);
    end
  end

  // Grant selection: first pass scans from rr_ptr upward, second pass wraps (round-robin only)
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {PW{1'b0}};
    head_s      = {EW{1'b0}};
    take_hi_s   = {NUM_PIPES{1'b0}};
    take_wrap_s = {NUM_PIPES{1'b0}};
    for (int i = 0; i < NUM_PIPES; i++) begin
      take_hi_s[i] = !grant_vld_s && nonempty_s[i] && (!RR_MODE || (PW'(i) >= rr_ptr_q));
      grant_vld_s  = grant_vld_s | take_hi_s[i];
      grant_idx_s  = take_hi_s[i] ? PW'(i) : grant_idx_s;
      head_s       = take_hi_s[i] ? mem_q[i][rd_ptr_q[i]] : head_s;
    end
    for (int i = 0; i < NUM_PIPES; i++) begin
      take_wrap_s[i] = RR_MODE && !grant_vld_s && nonempty_s[i];
      grant_vld_s    = grant_vld_s | take_wrap_s[i];
      grant_idx_s    = take_wrap_s[i] ? PW'(i) : grant_idx_s;
      head_s         = take_wrap_s[i] ? mem_q[i][rd_ptr_q[i]] : head_s;
    end
  end

  // FIFO push/pop bookkeeping; simultaneous push and pop keeps the count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_s   = {NUM_PIPES{1'b0}};
    pop_s    = {NUM_PIPES{1'b0}};
    for (int i = 0; i < NUM_PIPES; i++) begin
      push_s[i] = in_valid[i] & in_ready[i];
      pop_s[i]  = grant_vld_s && (grant_idx_s == PW'(i));
      if (push_s[i]) begin
        mem_d[i][wr_ptr_q[i]] = {in_reg_write[i], in_rd[i*REG_W +: REG_W], in_data[i*DATA_W +: DATA_W]};
      end else begin
        mem_d[i][wr_ptr_q[i]] = mem_q[i][wr_ptr_q[i]];
      end
      wr_ptr_d[i] = push_s[i] ? (wr_ptr_q[i] + PTR_ONE) : wr_ptr_q[i];
      rd_ptr_d[i] = pop_s[i]  ? (rd_ptr_q[i] + PTR_ONE) : rd_ptr_q[i];
      case ({push_s[i], pop_s[i]})
        2'b10:   count_d[i] = count_q[i] + CNT_ONE;
        2'b01:   count_d[i] = count_q[i] - CNT_ONE;
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // Output register next-state; rd==0 or !reg_write entries still use their slot
  always_comb begin
    head_rw_s   = head_s[EW-1];
    head_rd_s   = head_s[DATA_W +: REG_W];
    head_data_s = head_s[DATA_W-1:0];
    wr_en_d     = grant_vld_s & head_rw_s & (head_rd_s != {REG_W{1'b0}});
    wr_rd_d     = grant_vld_s ? head_rd_s   : wr_rd_q;
    wr_data_d   = grant_vld_s ? head_data_s : wr_data_q;
    wr_pipe_d   = grant_vld_s ? grant_idx_s : wr_pipe_q;
    out_vld_d   = grant_vld_s;
    if (!grant_vld_s) begin
      rr_ptr_d = rr_ptr_q;
    end else if (grant_idx_s == LAST_PIPE) begin
      rr_ptr_d = {PW{1'b0}};
    end else begin
      rr_ptr_d = grant_idx_s + PIPE_ONE;
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        wr_ptr_q[i] <= {AW{1'b0}};
        rd_ptr_q[i] <= {AW{1'b0}};
        count_q[i]  <= {CW{1'b0}};
      end
      rr_ptr_q  <= {PW{1'b0}};
      wr_en_q   <= 1'b0;
      wr_rd_q   <= {REG_W{1'b0}};
      wr_data_q <= {DATA_W{1'b0}};
      wr_pipe_q <= {PW{1'b0}};
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      wr_pipe_q <= wr_pipe_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Entry storage; stale contents are unreachable once pointers are cleared
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign wr_en   = wr_en_q;
  assign wr_rd   = wr_rd_q;
  assign wr_data = wr_data_q;
  assign wr_pipe = wr_pipe_q;
  assign pending = out_vld_q | (|nonempty_s);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a fixed-priority and a round-robin instance, each with
// a queue of expected register-file writes checked as the writes appear.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]   in_valid_fx, in_ready_fx, in_reg_write_fx;
  logic [19:0]  in_rd_fx;
  logic [127:0] in_data_fx;
  logic         wr_en_fx, pending_fx;
  logic [4:0]   wr_rd_fx;
  logic [31:0]  wr_data_fx;
  logic [1:0]   wr_pipe_fx;

  logic [3:0]   in_valid_rr, in_ready_rr, in_reg_write_rr;
  logic [19:0]  in_rd_rr;
  logic [127:0] in_data_rr;
  logic         wr_en_rr, pending_rr;
  logic [4:0]   wr_rd_rr;
  logic [31:0]  wr_data_rr;
  logic [1:0]   wr_pipe_rr;

  wb_arbiter #(.NUM_PIPES(4), .DATA_W(32), .REG_W(5), .DEPTH(2), .ARB_MODE(0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_fx), .in_ready(in_ready_fx),
    .in_reg_write(in_reg_write_fx), .in_rd(in_rd_fx), .in_data(in_data_fx),
    .wr_en(wr_en_fx), .wr_rd(wr_rd_fx), .wr_data(wr_data_fx), .wr_pipe(wr_pipe_fx),
    .pending(pending_fx));

  wb_arbiter #(.NUM_PIPES(4), .DATA_W(32), .REG_W(5), .DEPTH(2), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_rr), .in_ready(in_ready_rr),
    .in_reg_write(in_reg_write_rr), .in_rd(in_rd_rr), .in_data(in_data_rr),
    .wr_en(wr_en_rr), .wr_rd(wr_rd_rr), .wr_data(wr_data_rr), .wr_pipe(wr_pipe_rr),
    .pending(pending_rr));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  pipe;
  } wr_t;

  typedef struct {
    int          pipe;
    bit          rw;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          exp_we;
  } vec_t;

  wr_t  sb_fx[$];
  wr_t  sb_rr[$];
  vec_t tbl[7];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic wr_t mk(input logic [4:0] rd, input logic [31:0] d, input logic [1:0] p);
    wr_t w;
    w.rd = rd; w.data = d; w.pipe = p;
    return w;
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((pending_fx || pending_rr || sb_fx.size() != 0 || sb_rr.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk(n < 60, name, n, 60);
  endtask

  // Write monitor: every wr_en must match the oldest expected write
  always @(posedge clk) begin
    wr_t got, exp;
    #1;
    if (wr_en_fx === 1'b1) begin
      got = mk(wr_rd_fx, wr_data_fx, wr_pipe_fx);
      if (sb_fx.size() == 0) chk(1'b0, "fx_unexpected_write", got, 0);
      else begin
        exp = sb_fx.pop_front();
        chk(got == exp, "fx_write", got, exp);
      end
    end
    if (wr_en_rr === 1'b1) begin
      got = mk(wr_rd_rr, wr_data_rr, wr_pipe_rr);
      if (sb_rr.size() == 0) chk(1'b0, "rr_unexpected_write", got, 0);
      else begin
        exp = sb_rr.pop_front();
        chk(got == exp, "rr_write", got, exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    bit acc0, acc1, seen_bp;
    logic [31:0] r;

    tbl[0] = '{2, 1'b1, 5'd7,  32'hDEADBEEF, 1'b1};
    tbl[1] = '{0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
    tbl[2] = '{3, 1'b1, 5'd1,  32'h00000000, 1'b1};
    tbl[3] = '{1, 1'b1, 5'd0,  32'h12345678, 1'b0};
    tbl[4] = '{2, 1'b0, 5'd5,  32'h87654321, 1'b0};
    tbl[5] = '{1, 1'b1, 5'd16, 32'hA5A5A5A5, 1'b1};
    tbl[6] = '{3, 1'b0, 5'd0,  32'h5A5A5A5A, 1'b0};

    rst_n = 1'b0;
    in_valid_fx = 4'h0; in_reg_write_fx = 4'h0; in_rd_fx = 20'h0; in_data_fx = 128'h0;
    in_valid_rr = 4'h0; in_reg_write_rr = 4'h0; in_rd_rr = 20'h0; in_data_rr = 128'h0;
    tick();
    tick();
    chk(wr_en_fx == 1'b0, "rst_wr_en", wr_en_fx, 0);
    chk(wr_rd_fx == 5'd0, "rst_wr_rd", wr_rd_fx, 0);
    chk(wr_data_fx == 32'd0, "rst_wr_data", wr_data_fx, 0);
    chk(wr_pipe_fx == 2'd0, "rst_wr_pipe", wr_pipe_fx, 0);
    rst_n = 1'b1;
    tick();
    chk(in_ready_fx == 4'hF, "rst_in_ready", in_ready_fx, 4'hF);
    chk(pending_fx == 1'b0, "rst_pending", pending_fx, 0);
    chk(in_ready_rr == 4'hF, "rst_in_ready_rr", in_ready_rr, 4'hF);

    // Single pushes, idle pipes carry junk with valid low
    for (int k = 0; k < 7; k++) begin
      r = $urandom();
      in_rd_fx        = r[19:0];
      in_data_fx      = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_reg_write_fx = 4'hF;
      in_valid_fx     = 4'h0;
      in_valid_fx[tbl[k].pipe]          = 1'b1;
      in_reg_write_fx[tbl[k].pipe]      = tbl[k].rw;
      in_rd_fx[tbl[k].pipe*5 +: 5]      = tbl[k].rd;
      in_data_fx[tbl[k].pipe*32 +: 32]  = tbl[k].data;
      if (tbl[k].exp_we) sb_fx.push_back(mk(tbl[k].rd, tbl[k].data, 2'(tbl[k].pipe)));
      tick();
      in_valid_fx = 4'h0;
      tick();
      chk(wr_en_fx == tbl[k].exp_we, "vec_wr_en", wr_en_fx, tbl[k].exp_we);
      chk(wr_pipe_fx == 2'(tbl[k].pipe), "vec_wr_pipe", wr_pipe_fx, tbl[k].pipe);
      tick();
      chk(pending_fx == 1'b0, "vec_pending_clear", pending_fx, 0);
      chk(wr_en_fx == 1'b0, "vec_wr_en_drop", wr_en_fx, 0);
    end
    wait_idle("vec_drain");

    // Fixed priority: four simultaneous pushes drain in pipe order
    in_valid_fx = 4'hF;
    in_reg_write_fx = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_rd_fx[i*5 +: 5]     = 5'(i + 1);
      in_data_fx[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      sb_fx.push_back(mk(5'(i + 1), 32'h1000_0000 + 32'(i), 2'(i)));
    end
    tick();
    in_valid_fx = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk(wr_en_fx == 1'b1, "prio_wr_en", wr_en_fx, 1);
      chk(wr_pipe_fx == 2'(i), "prio_order", wr_pipe_fx, i);
    end
    tick();
    chk(wr_en_fx == 1'b0, "prio_idle_wr_en", wr_en_fx, 0);
    chk(wr_rd_fx == 5'd4, "prio_hold_rd", wr_rd_fx, 4);
    chk(pending_fx == 1'b0, "prio_pending", pending_fx, 0);
    wait_idle("prio_drain");

    // Backpressure: pipe 0 streams, pipe 1 fills and waits
    for (int k = 0; k < 6; k++) sb_fx.push_back(mk(5'(8 + k), 32'h0A00_0000 + 32'(k), 2'd0));
    for (int j = 0; j < 3; j++) sb_fx.push_back(mk(5'(20 + j), 32'h0B00_0000 + 32'(j), 2'd1));
    a0 = 0; a1 = 0; seen_bp = 1'b0;
    in_reg_write_fx = 4'hF;
    for (int cyc = 0; cyc < 40 && (a0 < 6 || a1 < 3); cyc++) begin
      in_valid_fx = 4'h0;
      if (a0 < 6) begin
        in_valid_fx[0]      = 1'b1;
        in_rd_fx[4:0]       = 5'(8 + a0);
        in_data_fx[31:0]    = 32'h0A00_0000 + 32'(a0);
      end
      if (a1 < 3) begin
        in_valid_fx[1]      = 1'b1;
        in_rd_fx[9:5]       = 5'(20 + a1);
        in_data_fx[63:32]   = 32'h0B00_0000 + 32'(a1);
      end
      acc0 = in_valid_fx[0] && in_ready_fx[0];
      acc1 = in_valid_fx[1] && in_ready_fx[1];
      tick();
      if (acc0) a0++;
      if (acc1) a1++;
      if (a1 == 2 && !seen_bp) begin
        seen_bp = 1'b1;
        chk(in_ready_fx[1] == 1'b0, "bp_ready1_low", in_ready_fx[1], 0);
      end
    end
    in_valid_fx = 4'h0;
    chk(a0 == 6 && a1 == 3, "bp_accepts", (a0 << 8) | a1, (6 << 8) | 3);
    wait_idle("bp_drain");

    // Suppressed writes still take the slot and update wr_pipe
    in_valid_fx = 4'b1000; in_reg_write_fx = 4'b1000; in_rd_fx = 20'h0;
    in_data_fx[127:96] = 32'hCAFE0003;
    tick();
    in_valid_fx = 4'b0100; in_reg_write_fx = 4'b0000;
    in_rd_fx[14:10] = 5'd5; in_data_fx[95:64] = 32'hCAFE0002;
    tick();
    chk(wr_en_fx == 1'b0, "sup_rd0_wr_en", wr_en_fx, 0);
    chk(wr_pipe_fx == 2'd3, "sup_rd0_pipe", wr_pipe_fx, 3);
    in_valid_fx = 4'h0;
    tick();
    chk(wr_en_fx == 1'b0, "sup_nowrite_wr_en", wr_en_fx, 0);
    chk(wr_pipe_fx == 2'd2, "sup_nowrite_pipe", wr_pipe_fx, 2);
    tick();
    chk(pending_fx == 1'b0, "sup_pending", pending_fx, 0);

    // Reset with three entries buffered; a push offered on the reset edge is refused
    in_valid_fx = 4'b1110; in_reg_write_fx = 4'hF; in_rd_fx = {5'd9, 5'd8, 5'd7, 5'd6};
    tick();
    in_valid_fx = 4'b0001;
    rst_n = 1'b0;
    tick();
    in_valid_fx = 4'h0;
    rst_n = 1'b1;
    chk(wr_en_fx == 1'b0, "mid_rst_wr_en", wr_en_fx, 0);
    chk(in_ready_fx == 4'hF, "mid_rst_in_ready", in_ready_fx, 4'hF);
    chk(pending_fx == 1'b0, "mid_rst_pending", pending_fx, 0);
    chk(wr_pipe_fx == 2'd0, "mid_rst_wr_pipe", wr_pipe_fx, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk(wr_en_fx == 1'b0, "post_rst_wr_en", wr_en_fx, 0);
      chk(pending_fx == 1'b0, "post_rst_pending", pending_fx, 0);
    end

    // Round-robin: pipes 0 and 3 with two entries each alternate
    sb_rr.push_back(mk(5'd11, 32'hC000_0000, 2'd0));
    sb_rr.push_back(mk(5'd12, 32'hC300_0000, 2'd3));
    sb_rr.push_back(mk(5'd13, 32'hC000_0001, 2'd0));
    sb_rr.push_back(mk(5'd14, 32'hC300_0001, 2'd3));
    in_reg_write_rr = 4'hF;
    in_valid_rr = 4'b1001;
    in_rd_rr[4:0] = 5'd11;   in_data_rr[31:0]   = 32'hC000_0000;
    in_rd_rr[19:15] = 5'd12; in_data_rr[127:96] = 32'hC300_0000;
    tick();
    in_rd_rr[4:0] = 5'd13;   in_data_rr[31:0]   = 32'hC000_0001;
    in_rd_rr[19:15] = 5'd14; in_data_rr[127:96] = 32'hC300_0001;
    tick();
    in_valid_rr = 4'h0;
    chk(wr_pipe_rr == 2'd0, "rr_first_grant", wr_pipe_rr, 0);
    tick();
    chk(wr_pipe_rr == 2'd3, "rr_second_grant", wr_pipe_rr, 3);
    wait_idle("rr_drain");
    chk(wr_en_rr == 1'b0, "rr_idle_wr_en", wr_en_rr, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_PIPES, default 4, meaning the number of execution pipes competing for the write-back port; legal range 2..8.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the write-back data width.
REQ-003 SHALL have parameter REG_W, default 5, meaning the destination register index width.
REQ-004 SHALL have parameter DEPTH, default 2, meaning the per-pipe buffer entries; must be a power of two, 2..8.
REQ-005 SHALL have parameter ARB_MODE, default 0, meaning the arbitration policy: 0 is fixed priority (lowest pipe index wins, ALU=0 highest), 1 is round-robin.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-008 SHALL have port in_valid, input, NUM_PIPES bits: pipe i presents a result.
REQ-009 SHALL have port in_ready, output, NUM_PIPES bits: buffer i not full.
REQ-010 SHALL have port in_reg_write, input, NUM_PIPES bits: the result targets the register file.
REQ-011 SHALL have port in_rd, input, NUM_PIPES*REG_W bits: destination registers, pipe i at slice i.
REQ-012 SHALL have port in_data, input, NUM_PIPES*DATA_W bits: result data, pipe i at slice i.
REQ-013 SHALL have port wr_en, output, 1 bit: register-file write strobe.
REQ-014 SHALL have port wr_rd, output, REG_W bits: write destination.
REQ-015 SHALL have port wr_data, output, DATA_W bits: write data.
REQ-016 SHALL have port wr_pipe, output, clog2(NUM_PIPES) bits: index of the pipe that wrote.
REQ-017 SHALL have port pending, output, 1 bit: any buffer is non-empty or the output register is valid.

Function
REQ-018 SHALL accept entry i on a clock edge where in_valid[i] and in_ready[i] are both high.
REQ-019 SHALL drive in_ready[i] from the buffer count only (count < DEPTH), never from same-cycle pops.
REQ-020 SHALL keep each buffer as a FIFO with wrapping read/write pointers of clog2(DEPTH) bits and a count of clog2(DEPTH)+1 bits.
REQ-021 SHALL grant one non-empty buffer per cycle, combinationally from the buffer heads, and pop it on the same edge.
REQ-022 SHALL register the granted head into wr_en/wr_rd/wr_data/wr_pipe, giving 2-cycle minimum latency: accepted at edge N, wr_en high in the cycle after edge N+1.
REQ-023 SHALL drive wr_en = head.reg_write AND (head.rd != 0); entries failing this are still popped and consume the grant slot; wr_pipe still reports them.
REQ-024 SHALL, in fixed mode, grant the lowest-index non-empty buffer.
REQ-025 SHALL, in round-robin mode, grant the first non-empty buffer at or after rr_ptr (wrapping modulo NUM_PIPES) and set rr_ptr = grant+1 mod NUM_PIPES after each grant; rr_ptr holds when nothing is granted.
REQ-026 SHALL, on simultaneous push and pop of one buffer, leave the count unchanged and keep FIFO order.
REQ-027 SHALL drive wr_en low in any cycle following an edge with no grant; wr_rd, wr_data and wr_pipe hold their previous values.
REQ-028 SHALL ignore in_reg_write/in_rd/in_data when in_valid is low.

Reset
REQ-029 SHALL, while rst_n is low at an edge, clear all counts and pointers, set rr_ptr=0, and drive wr_en=0, wr_rd=0, wr_data=0, wr_pipe=0.
REQ-030 SHALL drive in_ready all-ones and pending=0 in the cycle after reset.
REQ-031 SHALL discard entries buffered when reset is asserted mid-operation, with no write issued after reset.
REQ-032 SHALL not accept inputs on a reset edge.

Verification
REQ-033 SHALL test a single push: pipe 2 pushes rd=7, data=0xDEADBEEF at edge 0 -> wr_en=1, wr_rd=7, wr_data=0xDEADBEEF, wr_pipe=2 after edge 1; pending=0 after edge 2.
REQ-034 SHALL test fixed priority: all 4 pipes push once at the same edge, with rd = 1..4 -> writes in pipe order 0, 1, 2, 3 on consecutive cycles.
REQ-035 SHALL test round-robin: with ARB_MODE=1, pipes 0 and 3 hold 2 entries each -> grant order 0, 3, 0, 3.
REQ-036 SHALL test backpressure: pipe 1 pushes 3 results while pipe 0 pushes continuously, DEPTH=2, fixed mode -> in_ready[1]=0 after 2 accepts; pipe 1 data is neither lost nor duplicated once pipe 0 stops.
REQ-037 SHALL test write suppression: a push with rd=0 and reg_write=1, then one with rd=5 and reg_write=0 -> wr_en=0 on both grants, wr_pipe still updated.
REQ-038 SHALL test reset mid-flight: rst_n low for one edge with 3 entries buffered -> no wr_en afterwards, in_ready all-ones, pending=0.
